// File: rtl/permutation_scheduler_pkg.sv
// Shared types and constants for the ASCON permutation scheduler.
// Optional abort path elsewhere is enabled by the PERM_ABORT_EN macro.
package permutation_scheduler_pkg;

    localparam int unsigned NB_ROUNDS_MAX = 12;
    localparam logic [3:0]  LAST_ROUND    = 4'(NB_ROUNDS_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perm_state_t;

    // ASCON round constants, indexed directly by round_o.
    function automatic logic [7:0] round_constant(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd0:    rc = 8'hf0;
            4'd1:    rc = 8'he1;
            4'd2:    rc = 8'hd2;
            4'd3:    rc = 8'hc3;
            4'd4:    rc = 8'hb4;
            4'd5:    rc = 8'ha5;
            4'd6:    rc = 8'h96;
            4'd7:    rc = 8'h87;
            4'd8:    rc = 8'h78;
            4'd9:    rc = 8'h69;
            4'd10:   rc = 8'h5a;
            4'd11:   rc = 8'h4b;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Saturate to NB_ROUNDS_MAX before subtracting so the result cannot underflow.
    function automatic logic [3:0] first_round(input logic [3:0] nb_rounds);
        logic [3:0] nb_sat;
        nb_sat = (nb_rounds > 4'(NB_ROUNDS_MAX)) ? 4'(NB_ROUNDS_MAX) : nb_rounds;
        return 4'(NB_ROUNDS_MAX) - nb_sat;
    endfunction

endpackage

// File: rtl/permutation_scheduler_if.sv
// Request/sequencing bundle between the mode FSM (master) and the scheduler (slave).
// The abort signal is present only when PERM_ABORT_EN is defined.
interface permutation_scheduler_if;

    logic       start;
    logic [3:0] nb_rounds;
`ifdef PERM_ABORT_EN
    logic       abort;
`endif
    logic [3:0] round;
    logic       init_sel;
    logic       state_en;
    logic       busy;
    logic       done;

`ifdef PERM_ABORT_EN
    modport master (output start, nb_rounds, abort,
                    input  round, init_sel, state_en, busy, done);
    modport slave  (input  start, nb_rounds, abort,
                    output round, init_sel, state_en, busy, done);
`else
    modport master (output start, nb_rounds,
                    input  round, init_sel, state_en, busy, done);
    modport slave  (input  start, nb_rounds,
                    output round, init_sel, state_en, busy, done);
`endif

endinterface

// File: rtl/permutation_scheduler_round_counter.sv
// 4-bit loadable round counter that holds at the last round index.
module round_counter
    import permutation_scheduler_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    output logic [3:0] count,
    output logic       last
);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !last) begin
            count <= count + 4'd1;
        end
    end

    assign last = (count == LAST_ROUND);

endmodule

// File: rtl/permutation_scheduler.sv
// Sequences 1..12 ASCON permutation rounds, one per clock, with a done pulse.
// Define PERM_ABORT_EN to add the abort path.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for start with a non-zero round count
//   ST_RUN  | one round per cycle, state register enabled
//   ST_DONE | single-cycle completion pulse, then back to idle
module permutation_scheduler
    import permutation_scheduler_pkg::*;
(
    input  logic                   clock_i,
    input  logic                   reset_i,
    permutation_scheduler_if.slave perm
);

    perm_state_t state_q, state_d;
    logic        first_q, first_d;
    logic        cnt_load;
    logic        cnt_inc;
    logic [3:0]  cnt_val;
    logic        cnt_last;

    round_counter u_round_counter (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .load     (cnt_load),
        .load_val (first_round(perm.nb_rounds)),
        .inc      (cnt_inc),
        .count    (cnt_val),
        .last     (cnt_last)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        first_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (perm.start && (perm.nb_rounds != 4'd0)) begin
                    state_d  = ST_RUN;
                    first_d  = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_inc = 1'b1;
`ifdef PERM_ABORT_EN
                // Abort beats the last-round transition: no done pulse.
                if (perm.abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_last) begin
                    state_d = ST_DONE;
                end
`else
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    always_comb begin
        perm.round    = 4'd0;
        perm.init_sel = 1'b0;
        perm.state_en = 1'b0;
        perm.busy     = 1'b0;
        perm.done     = 1'b0;
        case (state_q)
            ST_RUN: begin
                perm.round    = cnt_val;
                perm.init_sel = first_q;
                perm.state_en = 1'b1;
                perm.busy     = 1'b1;
            end
            ST_DONE: begin
                perm.done = 1'b1;
                perm.busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
